sensor_acquisition: RTL and testbench

Front end that produces the sensor inputs consumed by the water controller. It periodically reads the 8-bit soil-moisture ADC over a 3-wire serial link and debounces three tank float probes into a 2-bit level code. Both results are presented as registered Moisture_sensor and Water_sensor values, updated together with a one-cycle Sample_valid strobe. It sits between the board pins and the water module.

---
 rtl/sensor_acquisition_if.sv | 21 ++
 rtl/sensor_acquisition.sv | 156 +++++++++++++++
 tb/tb_sensor_acquisition.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_acquisition_if.sv
// Pin-level bundle between the acquisition front end and the board/water module:
// the 3-wire ADC link plus the registered sample outputs.
interface sensor_acquisition_if;
  logic       ADC_CS_n;
  logic       ADC_SCLK;
  logic       ADC_DOUT;
  logic [7:0] Moisture_sensor;
  logic [1:0] Water_sensor;
  logic       Sample_valid;
  logic       Probe_fault;

  modport master (
    output ADC_CS_n, ADC_SCLK, Moisture_sensor, Water_sensor, Sample_valid, Probe_fault,
    input  ADC_DOUT
  );

  modport slave (
    input  ADC_CS_n, ADC_SCLK, Moisture_sensor, Water_sensor, Sample_valid, Probe_fault,
    output ADC_DOUT
  );
endinterface

// File: rtl/sensor_acquisition.sv
// Periodic 8-bit serial ADC reader plus debounced tank-probe level encoder.
// Both results are published together on a one-cycle Sample_valid strobe.
module sensor_acquisition #(
  parameter int SAMPLE_PERIOD = 64,
  parameter int SCLK_DIV      = 2,
  parameter int DEBOUNCE      = 4
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic [2:0]           Probe,
  sensor_acquisition_if.master bus
);

  localparam int PERIOD_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int DIV_W    = $clog2(SCLK_DIV + 1);
  localparam int DEB_W    = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] period_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [3:0]          half_cnt;
  logic                sclk_q;
  logic [7:0]          shift_q;

  logic [2:0]          sync1_q, sync2_q, deb_q;
  logic [DEB_W-1:0]    deb_cnt [3];
  logic [1:0]          level;
  logic                level_fault;

  logic period_hit, div_hit, last_toggle;

  assign period_hit  = Enable && (period_cnt == PERIOD_W'(SAMPLE_PERIOD - 1));
  assign div_hit     = (div_cnt == DIV_W'(SCLK_DIV - 1));
  // 16th SCLK half-period ends: SCLK has just completed its final high phase.
  assign last_toggle = div_hit && (half_cnt == 4'd15);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (period_hit)  state_d = SETUP;
      SETUP:                  state_d = SHIFT;
      SHIFT: if (last_toggle) state_d = DONE;
      DONE:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ADC_CS_n     = 1'b1;
    bus.Sample_valid = 1'b0;
    unique case (state_q)
      IDLE:  ;
      SETUP: bus.ADC_CS_n     = 1'b0;
      SHIFT: bus.ADC_CS_n     = 1'b0;
      DONE:  bus.Sample_valid = 1'b1;
    endcase
  end

  assign bus.ADC_SCLK = sclk_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      period_cnt <= '0;
    end else if (state_q == IDLE && Enable) begin
      period_cnt <= period_hit ? '0 : period_cnt + 1'b1;
    end else begin
      period_cnt <= '0;
    end
  end

  // Serial engine: ADC_DOUT is captured on the edge where SCLK rises.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk_q   <= 1'b0;
      shift_q  <= '0;
    end else if (state_q == SHIFT) begin
      if (div_hit) begin
        div_cnt  <= '0;
        sclk_q   <= ~sclk_q;
        half_cnt <= half_cnt + 1'b1;
        if (!sclk_q) shift_q <= {shift_q[6:0], bus.ADC_DOUT};
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else begin
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk_q   <= 1'b0;
    end
  end

  // NOTE: the per-bit debounce counters are plain flops, not RAM, so they
  // are reset along with everything else.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1_q <= Probe;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (deb_cnt[i] == DEB_W'(DEBOUNCE - 1)) begin
            deb_q[i]   <= sync2_q[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    level       = 2'd0;
    level_fault = 1'b0;
    case (deb_q)
      3'b000:  level = 2'd0;
      3'b001:  level = 2'd1;
      3'b011:  level = 2'd2;
      3'b111:  level = 2'd3;
      default: level_fault = 1'b1;
    endcase
  end

  // Loaded on the edge entering DONE so the new values are visible during
  // the Sample_valid cycle and held until the next one.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      bus.Moisture_sensor <= '0;
      bus.Water_sensor    <= '0;
      bus.Probe_fault     <= 1'b0;
    end else if (state_q == SHIFT && last_toggle) begin
      bus.Moisture_sensor <= shift_q;
      bus.Probe_fault     <= level_fault;
      if (!level_fault) bus.Water_sensor <= level;
    end
  end

endmodule

// File: tb/tb_sensor_acquisition.sv
// Scoreboard bench for sensor_acquisition: directed ADC words and probe patterns,
// with a behavioural ADC and a monitor that checks every Sample_valid strobe.
module tb_sensor_acquisition;

  localparam int SAMPLE_PERIOD = 64;
  localparam int SCLK_DIV      = 2;
  localparam int DEBOUNCE      = 4;
  localparam int LATENCY       = 1 + 16 * SCLK_DIV + 1;   // SETUP..DONE inclusive
  localparam int SPACING       = SAMPLE_PERIOD + LATENCY;  // CS_n fall to CS_n fall

  typedef struct packed {
    logic [7:0] moist;
    logic [1:0] water;
    logic       fault;
  } exp_t;

  logic       CLK    = 1'b0;
  logic       Reset  = 1'b0;
  logic       Enable = 1'b0;
  logic [2:0] Probe  = 3'b000;

  sensor_acquisition_if bus ();

  sensor_acquisition #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .SCLK_DIV     (SCLK_DIV),
    .DEBOUNCE     (DEBOUNCE)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .Enable(Enable),
    .Probe (Probe),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  int         n_valid = 0;
  int         sclk_rises = 0;
  int         cs_falls[$];
  exp_t       exp_q[$];
  logic [7:0] adc_q[$];
  exp_t       mon_e;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural ADC: loads the next word when CS_n falls, presents MSB first,
  // and advances to the next bit on each falling SCLK.
  logic [7:0] adc_word = 8'h00;
  int         adc_idx  = 8;

  assign bus.ADC_DOUT = (adc_idx < 8) ? adc_word[7 - adc_idx] : 1'b0;

  always @(negedge bus.ADC_CS_n) begin
    adc_idx = 0;
    if (adc_q.size() > 0) adc_word = adc_q.pop_front();
    else                  adc_word = 8'h00;
  end

  always @(negedge bus.ADC_SCLK) begin
    if (!bus.ADC_CS_n) adc_idx++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: tracks CS_n falls and SCLK rises, and scores every Sample_valid.
  logic cs_prev   = 1'b1;
  logic sclk_prev = 1'b0;

  always @(negedge CLK) begin
    if (cs_prev && bus.ADC_CS_n === 1'b0) begin
      cs_falls.push_back(cyc);
      sclk_rises = 0;
    end
    if (!sclk_prev && bus.ADC_SCLK === 1'b1) sclk_rises++;
    cs_prev   = bus.ADC_CS_n;
    sclk_prev = bus.ADC_SCLK;

    if (bus.Sample_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("moisture",   bus.Moisture_sensor, mon_e.moist);
        check("water",      bus.Water_sensor,    mon_e.water);
        check("fault",      bus.Probe_fault,     mon_e.fault);
        check("latency",    cyc - cs_falls[$] + 1, LATENCY);
        check("sclk_rises", sclk_rises,          8);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic expect_conv(input logic [7:0] word, input logic [7:0] moist,
                             input logic [1:0] water, input logic fault);
    adc_q.push_back(word);
    exp_q.push_back({moist, water, fault});
  endtask

  task automatic wait_valid(input int target);
    int k = 0;
    while (n_valid < target && k < 1000) begin
      tick(1);
      k++;
    end
    check("valid_arrived", n_valid >= target, 1);
  endtask

  task automatic wait_cs_fall(input int target);
    int k = 0;
    while (cs_falls.size() < target && k < 1000) begin
      tick(1);
      k++;
    end
    check("cs_fall_arrived", cs_falls.size() >= target, 1);
  endtask

  task automatic wait_sclk(input int target);
    int k = 0;
    while (sclk_rises < target && k < 200) begin
      tick(1);
      k++;
    end
    check("sclk_arrived", sclk_rises >= target, 1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_cs_n"},  bus.ADC_CS_n,        1);
    check({tag, "_sclk"},  bus.ADC_SCLK,        0);
    check({tag, "_moist"}, bus.Moisture_sensor, 0);
    check({tag, "_water"}, bus.Water_sensor,    0);
    check({tag, "_valid"}, bus.Sample_valid,    0);
    check({tag, "_fault"}, bus.Probe_fault,     0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int t0;

    tick(3);
    check_cleared("reset");
    Reset = 1'b1;

    // Default conversion followed by back-to-back conversions, level 2.
    Probe = 3'b011;
    tick(10);
    base = cs_falls.size();
    expect_conv(8'h20, 8'd32,  2'd2, 1'b0);
    expect_conv(8'hA0, 8'd160, 2'd2, 1'b0);
    expect_conv(8'h20, 8'd32,  2'd2, 1'b0);
    Enable = 1'b1;
    wait_valid(3);
    Enable = 1'b0;
    check("spacing_1", cs_falls[base + 1] - cs_falls[base],     SPACING);
    check("spacing_2", cs_falls[base + 2] - cs_falls[base + 1], SPACING);

    // 3-cycle glitch to 011 is rejected; a 10-cycle hold is accepted.
    Probe = 3'b001;
    tick(10);
    Probe = 3'b011;
    tick(3);
    Probe = 3'b001;
    tick(10);
    expect_conv(8'h55, 8'd85, 2'd1, 1'b0);
    Enable = 1'b1;
    wait_valid(4);
    Enable = 1'b0;
    Probe = 3'b011;
    tick(10);
    expect_conv(8'h0F, 8'd15, 2'd2, 1'b0);
    Enable = 1'b1;
    wait_valid(5);
    Enable = 1'b0;

    // Full tank, then non-thermometer 101 keeps level 3 with fault, then recovers.
    Probe = 3'b111;
    tick(10);
    expect_conv(8'hFF, 8'd255, 2'd3, 1'b0);
    Enable = 1'b1;
    wait_valid(6);
    Enable = 1'b0;
    Probe = 3'b101;
    tick(10);
    expect_conv(8'h01, 8'd1, 2'd3, 1'b1);
    Enable = 1'b1;
    wait_valid(7);
    Enable = 1'b0;
    Probe = 3'b111;
    tick(10);
    expect_conv(8'h80, 8'd128, 2'd3, 1'b0);
    Enable = 1'b1;
    wait_valid(8);
    Enable = 1'b0;

    // Enable dropped a few cycles into SHIFT: conversion still completes.
    expect_conv(8'h3C, 8'd60, 2'd3, 1'b0);
    base = cs_falls.size();
    Enable = 1'b1;
    wait_cs_fall(base + 1);
    tick(6);
    Enable = 1'b0;
    wait_valid(9);
    tick(150);
    check("no_cs_while_disabled", cs_falls.size(), base + 1);
    Enable = 1'b1;
    t0 = cyc;
    expect_conv(8'hC3, 8'd195, 2'd3, 1'b0);
    wait_cs_fall(base + 2);
    check("reenable_delay", cs_falls[base + 1] - t0, SAMPLE_PERIOD);
    wait_valid(10);
    Enable = 1'b0;

    // Reset after 3 bits aborts the conversion and clears all outputs at once.
    adc_q.push_back(8'h99);
    base = cs_falls.size();
    Enable = 1'b1;
    wait_cs_fall(base + 1);
    wait_sclk(3);
    Reset = 1'b0;
    #1;
    check_cleared("abort");
    tick(2);
    Reset = 1'b1;
    t0 = cyc;
    expect_conv(8'h42, 8'd66, 2'd3, 1'b0);
    wait_cs_fall(base + 2);
    check("post_reset_delay", cs_falls[base + 1] - t0, SAMPLE_PERIOD);
    wait_valid(11);
    Enable = 1'b0;

    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
    check("valid_count", n_valid, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
